// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one cacheSim port among NUM_REQ requesters, with flush
// sequencing. Define CACHE_ARB_STATS_EN to add grant_count/stall_cycles statistics outputs.
module cache_req_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ADDRESS_SIZE = 16,
    localparam int unsigned SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_rw,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            cache_en,
    output logic                            cache_rw,
    output logic [ADDRESS_SIZE-1:0]         cache_addr,
    output logic [SRC_W-1:0]                cache_src,
    input  logic                            cache_busy,
    output logic                            cache_reset,
    input  logic                            flush_req,
    output logic                            flush_done
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]           grant_count,
    output logic [31:0]                     stall_cycles
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StStall,
        StDrain,
        StFlush,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic                    cache_en_q, cache_en_d;
    logic                    cache_rw_q, cache_rw_d;
    logic [ADDRESS_SIZE-1:0] cache_addr_q, cache_addr_d;
    logic [SRC_W-1:0]        cache_src_q, cache_src_d;
    logic [SRC_W-1:0]        last_grant_q, last_grant_d;
    logic                    cache_reset_q, cache_reset_d;
    logic                    flush_done_q, flush_done_d;
    logic                    flush_armed_q, flush_armed_d;

    logic                    grant_valid;
    logic [SRC_W-1:0]        grant_idx;
    logic [SRC_W-1:0]        cand;
    logic                    grant_rw;
    logic [ADDRESS_SIZE-1:0] grant_addr;
    logic                    consume;
    logic                    flush_go;
    logic                    load_ok;
    logic                    grant;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = SRC_W'((32'(last_grant_q) + i) % NUM_REQ);
            if (!grant_valid && req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_rw   = 1'b0;
        grant_addr = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == SRC_W'(k)) begin
                grant_rw   = req_rw[k];
                grant_addr = req_addr[k*ADDRESS_SIZE +: ADDRESS_SIZE];
            end
        end
    end

    assign consume  = cache_en_q & ~cache_busy;
    assign flush_go = flush_req & flush_armed_q;
    assign load_ok  = ((state_q == StIdle) || (state_q == StIssue)) &&
                      (!cache_en_q || consume) && !flush_go && !reset;
    assign grant    = load_ok & grant_valid;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (flush_go) begin
                    state_d = StFlush;
                end else if (grant) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (consume) begin
                    if (flush_go) begin
                        state_d = StFlush;
                    end else if (grant) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    state_d = flush_go ? StDrain : StStall;
                end
            end
            StStall: begin
                if (flush_go) begin
                    state_d = StDrain;
                end else if (consume) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (!cache_en_q || consume) begin
                    state_d = StFlush;
                end
            end
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cache_en_d   = cache_en_q;
        cache_rw_d   = cache_rw_q;
        cache_addr_d = cache_addr_q;
        cache_src_d  = cache_src_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            cache_en_d   = 1'b1;
            cache_rw_d   = grant_rw;
            cache_addr_d = grant_addr;
            cache_src_d  = grant_idx;
            last_grant_d = grant_idx;
        end else if (consume) begin
            cache_en_d = 1'b0;
        end

        // A held-high flush_req fires once; it must drop before it can fire again.
        flush_armed_d = flush_armed_q;
        if (!flush_req) begin
            flush_armed_d = 1'b1;
        end else if (flush_go && ((state_q == StIdle) || (state_q == StIssue) ||
                                  (state_q == StStall))) begin
            flush_armed_d = 1'b0;
        end

        cache_reset_d = (state_d == StFlush);
        flush_done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cache_en_q    <= 1'b0;
            cache_rw_q    <= 1'b0;
            cache_addr_q  <= '0;
            cache_src_q   <= '0;
            last_grant_q  <= SRC_W'(NUM_REQ - 1);
            cache_reset_q <= 1'b0;
            flush_done_q  <= 1'b0;
            flush_armed_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cache_en_q    <= cache_en_d;
            cache_rw_q    <= cache_rw_d;
            cache_addr_q  <= cache_addr_d;
            cache_src_q   <= cache_src_d;
            last_grant_q  <= last_grant_d;
            cache_reset_q <= cache_reset_d;
            flush_done_q  <= flush_done_d;
            flush_armed_q <= flush_armed_d;
        end
    end

    assign cache_en    = cache_en_q;
    assign cache_rw    = cache_rw_q;
    assign cache_addr  = cache_addr_q;
    assign cache_src   = cache_src_q;
    assign cache_reset = cache_reset_q;
    assign flush_done  = flush_done_q;

`ifdef CACHE_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] grant_count_q, grant_count_d;
    logic [31:0]           stall_cycles_q, stall_cycles_d;

    always_comb begin
        grant_count_d  = grant_count_q;
        stall_cycles_d = stall_cycles_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (consume && (cache_src_q == SRC_W'(k)) &&
                (grant_count_q[k*32 +: 32] != 32'hFFFF_FFFF)) begin
                grant_count_d[k*32 +: 32] = grant_count_q[k*32 +: 32] + 32'd1;
            end
        end
        if (cache_en_q && cache_busy && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            grant_count_q  <= grant_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign grant_count  = grant_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed self-checking bench for cache_req_arbiter (NUM_REQ=2, ADDRESS_SIZE=16).
module tb_cache_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_rw;
    logic [31:0] req_addr;
    logic [1:0]  req_ready;
    logic        cache_en;
    logic        cache_rw;
    logic [15:0] cache_addr;
    logic [0:0]  cache_src;
    logic        cache_busy;
    logic        cache_reset;
    logic        flush_req;
    logic        flush_done;
`ifdef CACHE_ARB_STATS_EN
    logic [63:0] grant_count;
    logic [31:0] stall_cycles;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cache_req_arbiter #(
        .NUM_REQ      (2),
        .ADDRESS_SIZE (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .cache_en     (cache_en),
        .cache_rw     (cache_rw),
        .cache_addr   (cache_addr),
        .cache_src    (cache_src),
        .cache_busy   (cache_busy),
        .cache_reset  (cache_reset),
        .flush_req    (flush_req),
        .flush_done   (flush_done)
`ifdef CACHE_ARB_STATS_EN
        ,
        .grant_count  (grant_count),
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b11;
        req_rw     = 2'b10;
        req_addr   = {16'hB111, 16'hA000};
        cache_busy = 1'b0;
        flush_req  = 1'b0;

        // Reset with every requester asking.
        tick();
        tick();
        check_eq("rst_en", cache_en, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_addr", cache_addr, 0);
        check_eq("rst_src", cache_src, 0);
        check_eq("rst_creset", cache_reset, 0);
        check_eq("rst_fdone", flush_done, 0);

        // Round-robin, one access per cycle, requester 0 first.
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("rr_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check_eq("rr_en", cache_en, 1);
            check_eq("rr_src", cache_src, i % 2);
            check_eq("rr_addr", cache_addr, (i % 2 == 0) ? 16'hA000 : 16'hB111);
            check_eq("rr_rw", cache_rw, (i % 2 == 0) ? 1'b0 : 1'b1);
        end

        // Stall for three cycles on a held access.
        req_valid = 2'b01;
        req_rw    = 2'b01;
        req_addr  = {16'hB111, 16'h1230};
        #1;
        check_eq("st_ready_load", req_ready, 2'b01);
        tick();
        check_eq("st_en", cache_en, 1);
        check_eq("st_addr", cache_addr, 16'h1230);
        check_eq("st_src", cache_src, 0);
        check_eq("st_rw", cache_rw, 1);
        cache_busy = 1'b1;
        #1;
        check_eq("st_ready_busy", req_ready, 0);
        tick();
        for (int j = 0; j < 2; j++) begin
            check_eq("st_hold_en", cache_en, 1);
            check_eq("st_hold_addr", cache_addr, 16'h1230);
            check_eq("st_hold_src", cache_src, 0);
            check_eq("st_hold_rw", cache_rw, 1);
            check_eq("st_hold_ready", req_ready, 0);
            tick();
        end
        cache_busy = 1'b0;
        #1;
        check_eq("st_release_en", cache_en, 1);
        check_eq("st_release_ready", req_ready, 0);
        tick();
        check_eq("st_consumed_en", cache_en, 0);
        req_valid = 2'b00;
        tick();

        // Flush raised while stalled: drain, then reset pulse, then done pulse.
        req_valid = 2'b10;
        req_rw    = 2'b00;
        req_addr  = {16'h2222, 16'h1230};
        #1;
        check_eq("fl_ready_load", req_ready, 2'b10);
        tick();
        check_eq("fl_addr", cache_addr, 16'h2222);
        check_eq("fl_src", cache_src, 1);
        req_valid  = 2'b00;
        cache_busy = 1'b1;
        tick();
        flush_req = 1'b1;
        req_valid = 2'b11;
        #1;
        check_eq("fl_stall_ready", req_ready, 0);
        tick();
        check_eq("fl_drain_en", cache_en, 1);
        check_eq("fl_drain_addr", cache_addr, 16'h2222);
        check_eq("fl_drain_ready", req_ready, 0);
        check_eq("fl_drain_creset", cache_reset, 0);
        tick();
        cache_busy = 1'b0;
        #1;
        check_eq("fl_drain2_ready", req_ready, 0);
        tick();
        check_eq("fl_flush_creset", cache_reset, 1);
        check_eq("fl_flush_en", cache_en, 0);
        check_eq("fl_flush_ready", req_ready, 0);
        tick();
        check_eq("fl_done_creset", cache_reset, 0);
        check_eq("fl_done_fdone", flush_done, 1);
        check_eq("fl_done_ready", req_ready, 0);
        tick();
        // flush_req still high: grants resume, no second flush.
        check_eq("fl_idle_fdone", flush_done, 0);
        check_eq("fl_idle_ready", req_ready, 2'b01);
        tick();
        check_eq("fl_resume_en", cache_en, 1);
        check_eq("fl_resume_src", cache_src, 0);
        for (int j = 0; j < 2; j++) begin
            check_eq("fl_held_creset", cache_reset, 0);
            check_eq("fl_held_fdone", flush_done, 0);
            tick();
        end

        // Low-then-high flush_req from IDLE: pulse at N+1, done at N+2.
        req_valid = 2'b00;
        flush_req = 1'b0;
        tick();
        tick();
        check_eq("fl2_idle_en", cache_en, 0);
        flush_req = 1'b1;
        tick();
        check_eq("fl2_creset", cache_reset, 1);
        check_eq("fl2_fdone_early", flush_done, 0);
        tick();
        check_eq("fl2_creset_off", cache_reset, 0);
        check_eq("fl2_fdone", flush_done, 1);
        flush_req = 1'b0;
        tick();
        check_eq("fl2_fdone_off", flush_done, 0);

        // Five accesses from requester 1 with two stall cycles.
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        req_rw   = 2'b00;
        req_addr = {16'h0BEE, 16'h0000};
        for (int c = 0; c < 10; c++) begin
            req_valid  = (c <= 7) ? 2'b10 : 2'b00;
            cache_busy = (c == 1 || c == 2);
            tick();
        end
        cache_busy = 1'b0;
        check_eq("stats_idle_en", cache_en, 0);
        check_eq("stats_last_src", cache_src, 1);
`ifdef CACHE_ARB_STATS_EN
        check_eq("stats_gc1", grant_count[63:32], 5);
        check_eq("stats_gc0", grant_count[31:0], 0);
        check_eq("stats_stall", stall_cycles, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("stats_rst_gc", grant_count, 0);
        check_eq("stats_rst_stall", stall_cycles, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
